mole_controller: RTL and testbench
==================================

# mole_controller

Game sequencer for the whack-a-mole datapath. Sits between the RNG, the debounced switch edge detector and the score updater: it runs the game timer, spawns moles at RNG-chosen positions, ages each lit mole, and converts switch edges and mole expiries into one-cycle `hit_pulse` / `miss_pulse` strobes. Its `mole_mask` drives LEDR directly.

## Interface
Parameters:
- `NUM_MOLES`, 18: mole positions, one per switch/LED.
- `MAX_ACTIVE`, 4: maximum simultaneously lit moles.
- `SPAWN_PERIOD`, 10: ticks between spawn attempts (≥1).
- `MOLE_LIFE`, 15: ticks a mole stays lit if not hit (≥1).
- `GAME_LEN`, 600: game duration in ticks (≥1, ≤65535).

Ports:
- `clk`  in  1: system clock (CLOCK_50).
- `rst_n`  in  1: synchronous, active-low reset.
- `tick`  in  1: one-cycle timebase strobe (100 ms in the top level).
- `start`  in  1: one-cycle start request.
- `rand_idx`  in  5: RNG output, sampled at spawn attempts.
- `edge_detect`  in  NUM_MOLES: one-cycle per-switch edge strobes.
- `mole_mask`  out  NUM_MOLES: lit moles.
- `hit_pulse`  out  1: one score increment.
- `miss_pulse`  out  1: one miss.
- `game_active`  out  1: high in RUN.
- `game_over`  out  1: high in OVER.
- `ticks_left`  out  16: remaining game ticks.

## Operation
- FSM states: IDLE, RUN, DRAIN, OVER. Reset → IDLE.
- IDLE/OVER: `start` → RUN. On entry: mole_mask=0, all life counters=0, spawn counter=0, ticks_left=GAME_LEN, pending counters=0.
- RUN: each `tick` decrements ticks_left. The tick that takes ticks_left from 1 to 0 moves the FSM to DRAIN. `start` in RUN is ignored.
- Spawn: the spawn counter increments on each tick. On the tick where it equals SPAWN_PERIOD-1, it wraps to 0 and a spawn is attempted.
- Spawn index: idx = rand_idx if rand_idx < NUM_MOLES, otherwise rand_idx − NUM_MOLES.
- The attempt is skipped (no retry) if mole idx is already lit, or if popcount(mole_mask) ≥ MAX_ACTIVE.
- On a successful spawn, mole_mask[idx] is set and life[idx] is loaded with MOLE_LIFE.
- Aging: on each tick, every lit mole's life counter decrements. A mole whose counter is 1 at the tick expires: its bit clears and it adds one miss event.
- Hit: edge_detect[j] while mole_mask[j]=1 clears bit j and adds one hit event. Multiple hits in one cycle add popcount hits.
- Event precedence on one mole in one cycle: hit > expiry. A spawn is never applied to a bit being cleared in the same cycle; it is skipped as occupied.
- Pulse queue: separate 5-bit hit and miss pending counters, each saturating at 31.
  - Each cycle: total = pend + new events. If total > 0, the pulse is asserted and pend becomes total−1; otherwise the pulse is low.
  - Hit and miss queues drain independently.
- DRAIN: mole_mask cleared with no miss events; edges are ignored. When both pending counters reach 0, the FSM moves to OVER.
- Reset mid-game: all state is discarded and no pulses are emitted in the following cycle.

## Timing
- Reset values: mole_mask=0, hit_pulse=0, miss_pulse=0, game_active=0, game_over=0, ticks_left=0.
- All outputs are registered.
- `start` at cycle N: game_active=1 and ticks_left=GAME_LEN at N+1.
- Spawn tick at cycle N: mole bit visible at N+1.
- Hit edge at cycle N (empty queue): bit clears at N+1, hit_pulse high at N+1.
- A mole spawned at tick T with no hit is lit for exactly MOLE_LIFE ticks. It clears, and miss_pulse fires, the cycle after the MOLE_LIFE-th tick.
- Back-to-back pulses: k queued events produce k consecutive high cycles.

## Configuration
- `MOLE_CTRL_PENALTY_EN` defined: in RUN, an edge_detect[j] with mole_mask[j]=0 adds one miss event (wrong-switch penalty).
- Not defined: such edges are ignored. Only expiries generate misses.

## Test plan
- Reset, start, GAME_LEN=5, 5 ticks: game_active for 5 ticks, ticks_left 5→0, DRAIN, game_over=1, mole_mask=0.
- SPAWN_PERIOD=2, rand_idx=20, 2 ticks: mole_mask=18'h00004 (idx 2) one cycle after the 2nd tick.
- Lit mole 2, MOLE_LIFE=3, no edges, 3 ticks: bit 2 clears and a single miss_pulse occurs the cycle after the 3rd tick.
- Moles 1, 5, 9 lit, edge_detect=18'h00222 in one cycle: mask=0 next cycle, hit_pulse high 3 consecutive cycles.
- Edge on mole 3 in the same cycle as its expiry tick: one hit_pulse, zero miss_pulse.
- Edge on unlit position 7: one miss_pulse with MOLE_CTRL_PENALTY_EN defined, none without; MAX_ACTIVE=1 with one mole lit: next spawn skipped.

Source files
------------

// File: rtl/mole_controller.sv
// mole_controller: whack-a-mole game sequencer (timer, mole spawn/aging, hit/miss strobes)
//
// Ports:
//   clk          in   system clock (CLOCK_50)
//   rst_n        in   synchronous active-low reset
//   tick         in   one-cycle timebase strobe
//   start        in   one-cycle start request (honoured in IDLE/OVER)
//   rand_idx     in   RNG value, folded into a mole index at spawn attempts
//   edge_detect  in   per-switch one-cycle edge strobes
//   mole_mask    out  lit moles (drives LEDR)
//   hit_pulse    out  one-cycle strobe per queued hit
//   miss_pulse   out  one-cycle strobe per queued miss
//   game_active  out  high while the game runs
//   game_over    out  high once the game has ended and all pulses are out
//   ticks_left   out  remaining game ticks
//
// Build option: define MOLE_CTRL_PENALTY_EN to count an edge on an unlit
// position as a miss while the game runs.
module mole_controller #(
    parameter int NUM_MOLES    = 18,
    parameter int MAX_ACTIVE   = 4,
    parameter int SPAWN_PERIOD = 10,
    parameter int MOLE_LIFE    = 15,
    parameter int GAME_LEN     = 600
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 start,
    input  logic [4:0]           rand_idx,
    input  logic [NUM_MOLES-1:0] edge_detect,
    output logic [NUM_MOLES-1:0] mole_mask,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 game_active,
    output logic                 game_over,
    output logic [15:0]          ticks_left
);
    localparam int LW = $clog2(MOLE_LIFE + 1);
    localparam int SW = $clog2(SPAWN_PERIOD + 1);
    localparam logic [LW-1:0] LIFE_INIT  = LW'(MOLE_LIFE);
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_PERIOD - 1);
    localparam logic [15:0]   GAME_TICKS = 16'(GAME_LEN);
    localparam logic [5:0]    NM         = 6'(NUM_MOLES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OVER} state_t;

    state_t                state, state_nxt;
    logic [NUM_MOLES-1:0]  mask_nxt, hits, expire, wrong, spawn_1h, spawn_hot;
    logic [LW-1:0]         life [NUM_MOLES];
    logic [LW-1:0]         life_nxt [NUM_MOLES];
    logic [SW-1:0]         spawn_cnt, spawn_nxt;
    logic [15:0]           ticks_nxt;
    logic [4:0]            hit_pend, miss_pend;
    logic [6:0]            hit_total, miss_total;
    logic [5:0]            idx;

    // Pending count after emitting one pulse this cycle, saturating at 31.
    function automatic logic [4:0] pend_next(input logic [6:0] t);
        return (t == 7'd0) ? 5'd0 : (t > 7'd32) ? 5'd31 : 5'(t - 7'd1);
    endfunction

    assign idx      = ({1'b0, rand_idx} < NM) ? {1'b0, rand_idx} : {1'b0, rand_idx} - NM;
    assign spawn_1h = NUM_MOLES'(1) << idx;

    always_comb begin
        state_nxt = state;
        mask_nxt  = mole_mask;
        life_nxt  = life;
        spawn_nxt = spawn_cnt;
        ticks_nxt = ticks_left;
        hits      = '0;
        expire    = '0;
        wrong     = '0;
        spawn_hot = '0;
        case (state)
            RUN: begin
                hits = edge_detect & mole_mask;
`ifdef MOLE_CTRL_PENALTY_EN
                wrong = edge_detect & ~mole_mask;
`endif
                if (tick) begin
                    ticks_nxt = ticks_left - 16'd1;
                    spawn_nxt = (spawn_cnt == SPAWN_LAST) ? '0 : spawn_cnt + 1'b1;
                    // Testing against the pre-clear mask also keeps a spawn off a bit cleared this cycle.
                    if (spawn_cnt == SPAWN_LAST && !(|(spawn_1h & mole_mask)) &&
                        $countones(mole_mask) < MAX_ACTIVE)
                        spawn_hot = spawn_1h;
                end
                for (int i = 0; i < NUM_MOLES; i++) begin
                    // A hit on an expiring mole wins: it never counts as a miss.
                    expire[i] = tick && mole_mask[i] && !hits[i] && life[i] == LW'(1);
                    if (spawn_hot[i])
                        life_nxt[i] = LIFE_INIT;
                    else if (hits[i] || expire[i])
                        life_nxt[i] = '0;
                    else if (tick && mole_mask[i])
                        life_nxt[i] = life[i] - 1'b1;
                end
                mask_nxt = (mole_mask & ~(hits | expire)) | spawn_hot;
                if (tick && ticks_left == 16'd1) begin
                    state_nxt = DRAIN;
                    mask_nxt  = '0;
                    life_nxt  = '{default: '0};
                end
            end
            DRAIN: begin
                mask_nxt = '0;
                if (hit_pend == 5'd0 && miss_pend == 5'd0)
                    state_nxt = OVER;
            end
            default: begin
                if (start) begin
                    state_nxt = RUN;
                    mask_nxt  = '0;
                    life_nxt  = '{default: '0};
                    spawn_nxt = '0;
                    ticks_nxt = GAME_TICKS;
                end
            end
        endcase
        hit_total  = 7'(hit_pend) + 7'($countones(hits));
        miss_total = 7'(miss_pend) + 7'($countones(expire)) + 7'($countones(wrong));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            mole_mask   <= '0;
            life        <= '{default: '0};
            spawn_cnt   <= '0;
            ticks_left  <= '0;
            hit_pend    <= '0;
            miss_pend   <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            game_active <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nxt;
            mole_mask   <= mask_nxt;
            life        <= life_nxt;
            spawn_cnt   <= spawn_nxt;
            ticks_left  <= ticks_nxt;
            hit_pend    <= pend_next(hit_total);
            miss_pend   <= pend_next(miss_total);
            hit_pulse   <= hit_total != 7'd0;
            miss_pulse  <= miss_total != 7'd0;
            game_active <= state_nxt == RUN;
            game_over   <= state_nxt == OVER;
        end
    end
endmodule

// File: tb/tb_mole_controller.sv
// tb_mole_controller: cycle-by-cycle vector check of mole_controller plus a full-game sequence
module tb_mole_controller;
`ifdef MOLE_CTRL_PENALTY_EN
    localparam logic PEN = 1'b1;
`else
    localparam logic PEN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0;
    logic [4:0]  rand_idx = '0;
    logic [17:0] edge_detect = '0, mole_mask;
    logic        hit_pulse, miss_pulse, game_active, game_over;
    logic [15:0] ticks_left;
    int          n_chk = 0, n_fail = 0;

    mole_controller #(
        .NUM_MOLES(18), .MAX_ACTIVE(3), .SPAWN_PERIOD(2), .MOLE_LIFE(7), .GAME_LEN(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .rand_idx(rand_idx),
        .edge_detect(edge_detect), .mole_mask(mole_mask), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .game_active(game_active), .game_over(game_over),
        .ticks_left(ticks_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rn, st, tk;
        logic [4:0]  ri;
        logic [17:0] ed, m;
        logic        h, ms, a, o;
        logic [15:0] tl;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic rn, st, tk, input logic [4:0] ri, input logic [17:0] ed, m,
                     input logic h, ms, a, o, input logic [15:0] tl);
        vq.push_back('{rn, st, tk, ri, ed, m, h, ms, a, o, tl});
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act, exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    initial begin
        int acts, misses, hits;
        logic done;
        //  rn st tk ri  edge       mask     h  ms   a  o  tl
        v(0, 0, 0, 0,  0,       0,       0, 0,   0, 0, 0);   // reset
        v(0, 1, 1, 0,  0,       0,       0, 0,   0, 0, 0);   // reset beats start
        v(1, 0, 0, 0,  0,       0,       0, 0,   0, 0, 0);
        v(1, 0, 1, 0,  0,       0,       0, 0,   0, 0, 0);   // tick ignored in IDLE
        v(1, 1, 0, 0,  0,       0,       0, 0,   1, 0, 10);  // start
        v(1, 1, 0, 0,  0,       0,       0, 0,   1, 0, 10);  // start ignored in RUN
        v(1, 0, 1, 20, 0,       0,       0, 0,   1, 0, 9);
        v(1, 0, 1, 20, 0,       18'h4,   0, 0,   1, 0, 8);   // spawn idx 20-18=2
        v(1, 0, 1, 2,  0,       18'h4,   0, 0,   1, 0, 7);
        v(1, 0, 1, 2,  0,       18'h4,   0, 0,   1, 0, 6);   // occupied: skipped
        v(1, 0, 0, 0,  18'h80,  18'h4,   0, PEN, 1, 0, 6);   // unlit edge
        v(1, 0, 1, 2,  0,       18'h4,   0, 0,   1, 0, 5);
        v(1, 0, 1, 20, 0,       18'h4,   0, 0,   1, 0, 4);
        v(1, 0, 1, 2,  0,       18'h4,   0, 0,   1, 0, 3);
        v(1, 0, 1, 2,  0,       18'h4,   0, 0,   1, 0, 2);
        v(1, 0, 1, 0,  0,       0,       0, 1,   1, 0, 1);   // 7th tick: expiry
        v(1, 0, 0, 0,  0,       0,       0, 0,   1, 0, 1);   // single miss
        v(1, 0, 1, 9,  0,       0,       0, 0,   0, 0, 0);   // last tick -> DRAIN
        v(1, 0, 0, 0,  18'h200, 0,       0, 0,   0, 1, 0);   // OVER, edge ignored
        v(1, 0, 1, 0,  0,       0,       0, 0,   0, 1, 0);
        v(1, 1, 0, 0,  0,       0,       0, 0,   1, 0, 10);  // restart
        v(1, 0, 1, 1,  0,       0,       0, 0,   1, 0, 9);
        v(1, 0, 1, 1,  0,       18'h2,   0, 0,   1, 0, 8);
        v(1, 0, 1, 0,  0,       18'h2,   0, 0,   1, 0, 7);
        v(1, 0, 1, 5,  0,       18'h22,  0, 0,   1, 0, 6);
        v(1, 0, 1, 0,  0,       18'h22,  0, 0,   1, 0, 5);
        v(1, 0, 1, 9,  0,       18'h222, 0, 0,   1, 0, 4);
        v(1, 0, 1, 0,  0,       18'h222, 0, 0,   1, 0, 3);
        v(1, 0, 1, 12, 0,       18'h222, 0, 0,   1, 0, 2);   // full: skipped
        v(1, 0, 1, 0,  18'h222, 0,       1, 0,   1, 0, 1);   // 3 hits, mole 1 expiring
        v(1, 0, 0, 0,  0,       0,       1, 0,   1, 0, 1);
        v(1, 0, 0, 0,  0,       0,       1, 0,   1, 0, 1);
        v(1, 0, 0, 0,  0,       0,       0, 0,   1, 0, 1);
        v(1, 0, 1, 3,  0,       0,       0, 0,   0, 0, 0);
        v(1, 0, 0, 0,  0,       0,       0, 0,   0, 1, 0);
        v(1, 1, 0, 0,  0,       0,       0, 0,   1, 0, 10);
        v(1, 0, 1, 4,  0,       0,       0, 0,   1, 0, 9);
        v(1, 0, 1, 4,  0,       18'h10,  0, 0,   1, 0, 8);
        v(1, 0, 1, 6,  0,       18'h10,  0, 0,   1, 0, 7);
        v(1, 0, 1, 6,  0,       18'h50,  0, 0,   1, 0, 6);
        v(1, 0, 0, 0,  18'h50,  0,       1, 0,   1, 0, 6);   // one hit out, one queued
        v(0, 0, 0, 0,  0,       0,       0, 0,   0, 0, 0);   // reset mid-game
        v(1, 0, 0, 0,  0,       0,       0, 0,   0, 0, 0);   // queued hit discarded
        v(1, 1, 0, 0,  0,       0,       0, 0,   1, 0, 10);
        v(1, 0, 1, 0,  0,       0,       0, 0,   1, 0, 9);
        v(1, 0, 1, 0,  0,       18'h1,   0, 0,   1, 0, 8);
        v(1, 0, 0, 0,  18'h1,   0,       1, 0,   1, 0, 8);
        v(1, 0, 1, 0,  0,       0,       0, 0,   1, 0, 7);
        v(1, 0, 1, 3,  0,       18'h8,   0, 0,   1, 0, 6);
        v(1, 0, 1, 0,  0,       18'h8,   0, 0,   1, 0, 5);
        v(1, 0, 1, 11, 0,       18'h808, 0, 0,   1, 0, 4);
        v(1, 0, 1, 0,  0,       18'h808, 0, 0,   1, 0, 3);
        v(1, 0, 1, 3,  0,       18'h808, 0, 0,   1, 0, 2);
        v(1, 0, 1, 0,  0,       18'h808, 0, 0,   1, 0, 1);
        v(1, 0, 1, 0,  18'h808, 0,       1, 0,   0, 0, 0);   // 2 hits on last tick
        v(1, 0, 0, 0,  0,       0,       1, 0,   0, 0, 0);   // DRAIN waits for queue
        v(1, 0, 0, 0,  0,       0,       0, 0,   0, 1, 0);

        foreach (vq[i]) begin
            rst_n       = vq[i].rn;
            start       = vq[i].st;
            tick        = vq[i].tk;
            rand_idx    = vq[i].ri;
            edge_detect = vq[i].ed;
            @(posedge clk);
            #1;
            chk("mole_mask",   i, 32'(mole_mask),   32'(vq[i].m));
            chk("hit_pulse",   i, 32'(hit_pulse),   32'(vq[i].h));
            chk("miss_pulse",  i, 32'(miss_pulse),  32'(vq[i].ms));
            chk("game_active", i, 32'(game_active), 32'(vq[i].a));
            chk("game_over",   i, 32'(game_over),   32'(vq[i].o));
            chk("ticks_left",  i, 32'(ticks_left),  32'(vq[i].tl));
        end

        // Full game with a tick every cycle: one mole at idx 0 expires, nothing else spawns.
        tick = 1'b0;
        edge_detect = '0;
        rand_idx = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tick = 1'b1;
        acts = int'(game_active);
        misses = 0;
        hits = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk);
            #1;
            acts += int'(game_active);
            misses += int'(miss_pulse);
            hits += int'(hit_pulse);
            done = game_over;
        end
        tick = 1'b0;
        chk("seq_game_over",     -1, 32'(done),       32'd1);
        chk("seq_active_cycles", -1, 32'(acts),       32'd10);
        chk("seq_misses",        -1, 32'(misses),     32'd1);
        chk("seq_hits",          -1, 32'(hits),       32'd0);
        chk("seq_mask",          -1, 32'(mole_mask),  32'd0);
        chk("seq_ticks_left",    -1, 32'(ticks_left), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
